// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse paddle tracker.
package mouse_pkg;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  typedef enum logic [2:0] {
    IN_BOOT,
    IN_INHIBIT,
    IN_REQ,
    IN_SEND,
    IN_ACK,
    IN_RESP,
    IN_DONE
  } init_state_t;

  localparam logic [7:0] PS2_ENABLE_CMD = 8'hF4;
  localparam logic [7:0] PS2_ACK        = 8'hFA;

  localparam int YSIGN = 5;
  localparam int YOVF  = 7;
  localparam int SYNC  = 3;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, 11-bit frame FSM,
// odd-parity/stop checks and an inactivity timeout.
module ps2_frame_rx
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  input  logic       rx_en,
  input  logic       hold,
  output logic       fall,
  output logic       data_s,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic            clk_meta, clk_s, clk_prev, data_meta;
  frame_state_t    state, state_n;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TW-1:0]   tcnt;
  logic            armed;

  // Synchronizers reset to the idle-high bus level so release never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      clk_meta  <= ps2clk_in;
      clk_s     <= clk_meta;
      clk_prev  <= clk_s;
      data_meta <= ps2data_in;
      data_s    <= data_meta;
    end
  end

  assign fall    = clk_prev & ~clk_s;
  assign armed   = (state != FR_IDLE) || hold;
  assign timeout = armed && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign rx_byte = shreg;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_n  = state;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    if (timeout || !rx_en) begin
      state_n = FR_IDLE;
    end else if (fall) begin
      case (state)
        FR_IDLE:   if (!data_s) state_n = FR_DATA;
        FR_DATA:   if (bit_cnt == 3'd7) state_n = FR_PARITY;
        FR_PARITY: state_n = FR_STOP;
        FR_STOP: begin
          state_n = FR_IDLE;
          // Device sends odd parity: the 9 bits must XOR to 1.
          if (data_s && (^{par_bit, shreg})) rx_valid = 1'b1;
          else                               rx_err   = 1'b1;
        end
        default:   state_n = FR_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FR_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      state <= state_n;
      if (state == FR_IDLE) bit_cnt <= 3'd0;
      if (fall && state == FR_DATA) begin
        shreg   <= {data_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (fall && state == FR_PARITY) par_bit <= data_s;
      if (!armed || fall || timeout) tcnt <= '0;
      else                           tcnt <= tcnt + TW'(1);
    end
  end

endmodule

// File: rtl/mouse_tracker.sv
// PS/2 mouse to paddle Y position tracker. Optional MOUSE_INIT_EN macro adds
// the host-to-device "enable reporting" (F4) handshake after reset.
module mouse_tracker
  import mouse_pkg::*;
#(
  parameter logic [9:0] PADDLE_MAX     = 10'd440,
  parameter logic [9:0] INIT_POS       = 10'd220,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         INHIBIT_CYCLES = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic [9:0] mousepos,
  output logic       pkt_valid,
  output logic       frame_err
);

  logic              fall, data_s, rx_valid, rx_err, timeout;
  logic [7:0]        rx_byte;
  logic              rx_en, rx_pkt, init_busy, hold;
  logic [1:0]        byte_idx;
  logic              b0_ysign, b0_yovf;
  logic signed [10:0] dy, pos_sum;
  logic [9:0]        next_pos;

  assign hold = init_busy || (byte_idx != 2'd0);

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2clk_in (ps2clk_in),
    .ps2data_in(ps2data_in),
    .rx_en     (rx_en),
    .hold      (hold),
    .fall      (fall),
    .data_s    (data_s),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .timeout   (timeout)
  );

`ifdef MOUSE_INIT_EN
  localparam int         IW       = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [8:0] TX_FRAME = {~^PS2_ENABLE_CMD, PS2_ENABLE_CMD};

  init_state_t ist, ist_n;
  logic [IW-1:0] icnt;
  logic [3:0]    tx_idx;

  // Clock is held low INHIBIT_CYCLES in total: INHIBIT plus the one-cycle REQ.
  always_comb begin
    ist_n      = ist;
    ps2clk_oe  = 1'b0;
    ps2data_oe = 1'b0;
    rx_en      = 1'b0;
    rx_pkt     = 1'b0;
    init_busy  = 1'b0;
    case (ist)
      IN_BOOT:    ist_n = IN_INHIBIT;
      IN_INHIBIT: begin
        ps2clk_oe = 1'b1;
        if (icnt == IW'(INHIBIT_CYCLES - 2)) ist_n = IN_REQ;
      end
      IN_REQ: begin
        ps2clk_oe  = 1'b1;
        ps2data_oe = 1'b1;
        ist_n      = IN_SEND;
      end
      IN_SEND: begin
        init_busy  = 1'b1;
        ps2data_oe = (tx_idx == 4'd0) ? 1'b1 : ~TX_FRAME[tx_idx - 4'd1];
        if (fall && tx_idx == 4'd9) ist_n = IN_ACK;
      end
      IN_ACK: begin
        init_busy = 1'b1;
        if (fall) ist_n = data_s ? IN_INHIBIT : IN_RESP;
      end
      IN_RESP: begin
        init_busy = 1'b1;
        rx_en     = 1'b1;
        if (rx_valid || rx_err) ist_n = IN_DONE;
      end
      default: begin
        rx_en  = 1'b1;
        rx_pkt = 1'b1;
      end
    endcase
    if (timeout && init_busy) ist_n = IN_INHIBIT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ist    <= IN_BOOT;
      icnt   <= '0;
      tx_idx <= 4'd0;
    end else begin
      ist    <= ist_n;
      icnt   <= (ist == IN_INHIBIT && ist_n == IN_INHIBIT) ? icnt + IW'(1) : '0;
      if (ist != IN_SEND) tx_idx <= 4'd0;
      else if (fall)      tx_idx <= tx_idx + 4'd1;
    end
  end
`else
  logic unused_cfg;

  assign ps2clk_oe  = 1'b0;
  assign ps2data_oe = 1'b0;
  assign rx_en      = 1'b1;
  assign rx_pkt     = 1'b1;
  assign init_busy  = 1'b0;
  assign unused_cfg = ^{data_s, (INHIBIT_CYCLES == 0)};
`endif

  // Y delta sign lives in byte 0; subtract so mouse-up moves the paddle up.
  always_comb begin
    dy       = {{2{b0_ysign}}, b0_ysign, rx_byte};
    pos_sum  = $signed({1'b0, mousepos}) - dy;
    next_pos = pos_sum[9:0];
    if (pos_sum < 0)                               next_pos = 10'd0;
    else if (pos_sum > $signed({1'b0, PADDLE_MAX})) next_pos = PADDLE_MAX;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mousepos  <= INIT_POS;
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      byte_idx  <= 2'd0;
      b0_ysign  <= 1'b0;
      b0_yovf   <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      if (timeout || rx_err) begin
        byte_idx  <= 2'd0;
        frame_err <= 1'b1;
      end else if (rx_valid && rx_pkt) begin
        case (byte_idx)
          2'd0: begin
            if (rx_byte[SYNC]) begin
              b0_ysign <= rx_byte[YSIGN];
              b0_yovf  <= rx_byte[YOVF];
              byte_idx <= 2'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          2'd1: byte_idx <= 2'd2;
          default: begin
            byte_idx  <= 2'd0;
            pkt_valid <= 1'b1;
            if (!b0_yovf) mousepos <= next_pos;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mouse_tracker.md
MOUSE_TRACKER -- requirements
Module: mouse_tracker

Interface
REQ-001 SHALL have parameter PADDLE_MAX, default 10'd440, the maximum paddle Y position.
REQ-002 SHALL have parameter INIT_POS, default 10'd220, the paddle position after reset.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, the clk cycles without a ps2clk falling edge before a partial frame/packet is aborted.
REQ-004 SHALL have parameter INHIBIT_CYCLES, default 4000, the clk cycles ps2clk is held low before a host command.
REQ-005 clk  input  1  system clock; the only clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 ps2clk_in  input  1  PS/2 clock pin level (asynchronous).
REQ-008 ps2data_in  input  1  PS/2 data pin level (asynchronous).
REQ-009 ps2clk_oe  output  1  1 = top level drives the ps2clk pin low.
REQ-010 ps2data_oe  output  1  1 = top level drives the ps2data pin low.
REQ-011 mousepos  output  10  paddle Y position, 0..PADDLE_MAX.
REQ-012 pkt_valid  output  1  one-cycle pulse when a 3-byte packet is accepted.
REQ-013 frame_err  output  1  one-cycle pulse on any frame, packet or timeout error.

Function
REQ-014 SHALL pass ps2clk_in and ps2data_in through 2-flop synchronizers, and act only on a synchronized ps2clk falling edge (1->0).
REQ-015 Frame FSM SHALL use states IDLE->DATA(8 bits, LSB first)->PARITY->STOP->IDLE, sampling data on each falling edge.
REQ-016 In IDLE, a start bit of 1 SHALL be ignored: stay in IDLE, no error.
REQ-017 Even parity over the 9 bits, or a stop bit of 0, SHALL discard the byte, pulse frame_err, and set the byte index to 0.
REQ-018 Byte index 0 SHALL be accepted only if bit3=1; otherwise the byte is discarded (resync) and frame_err pulses.
REQ-019 Byte 1 (X delta) SHALL be stored and ignored; byte 2 SHALL be the Y delta with sign = byte0 bit5, forming a 9-bit signed dy.
REQ-020 Update rule: the next position SHALL be mousepos - dy, computed in 11-bit signed and clamped to [0, PADDLE_MAX].
REQ-021 If byte0 bit7 (Y overflow) =1, mousepos SHALL be unchanged, but pkt_valid still pulses.
REQ-022 mousepos SHALL update, and pkt_valid pulse, exactly 1 clk after the cycle in which the byte-2 stop bit is sampled.
REQ-023 If TIMEOUT_CYCLES pass with no falling edge while a frame is active or the byte index is nonzero, the block SHALL return to IDLE with byte index 0 and pulse frame_err once.
REQ-024 frame_err and pkt_valid SHALL never assert in the same cycle; a stop-bit error on byte 2 produces no position update.
REQ-025 Without MOUSE_INIT_EN, ps2clk_oe and ps2data_oe SHALL be constant 0.

Reset
REQ-026 While reset=0, outputs SHALL be: mousepos=INIT_POS, pkt_valid=0, frame_err=0, ps2clk_oe=0, ps2data_oe=0; the FSMs SHALL be in IDLE with byte index 0 and the timeout counter at 0.
REQ-027 Reset asserted mid-frame SHALL discard all partial bytes; after release, the first byte is taken as byte 0.

Configuration
REQ-028 Macro MOUSE_INIT_EN: when defined, after reset release the block SHALL send 8'hF4 (enable reporting) before receiving.
REQ-029 Send sequence: ps2clk_oe=1 for INHIBIT_CYCLES; then ps2data_oe=1; then ps2clk_oe=0. On each device falling edge, drive 8 data bits LSB first, then parity=0, then release the line for stop. Then wait for the device ack (data low), then receive the 8'hFA response byte, which is discarded and never treated as packet byte 0.
REQ-030 A timeout during the send SHALL restart the send sequence from the inhibit phase.
REQ-031 When MOUSE_INIT_EN is not defined, no send logic is synthesized and reception starts immediately after reset.

Structure
REQ-032 Package mouse_pkg SHALL hold the frame-FSM and init-FSM state enums, PS2_ENABLE_CMD=8'hF4, PS2_ACK=8'hFA, and the packet bit positions (YSIGN=5, YOVF=7, SYNC=3).
REQ-033 Sub-module ps2_frame_rx SHALL hold the synchronizers, frame FSM, parity/stop checks and timeout counter, and output a byte plus a valid/error strobe.

Verification
REQ-034 Packet 08,00,05 from reset (pos 220) -> mousepos=215, pkt_valid pulses once, 1 clk after byte-2 stop.
REQ-035 Packet 28,00,F6 (dy=-10) with pos 435 -> mousepos=440 (clamped); packet 08,00,7F with pos 20 -> mousepos=0.
REQ-036 Byte with bad parity as byte 1 -> frame_err pulse; the following valid 08,00,01 -> mousepos decremented by 1.
REQ-037 Byte 00 at index 0, then 08,00,02 -> frame_err once, then mousepos-=2.
REQ-038 Two bytes sent, then idle for 100000 clk -> frame_err pulse; the next 3-byte packet is applied normally.
REQ-039 With MOUSE_INIT_EN: after reset, ps2clk_oe is high for 4000 clk, the bits observed are 0,F4 LSB-first,0; then ack and FA are sent, then 08,00,03 -> mousepos=217.
